// File: rtl/unified_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bundles the signals between the unified memory arbiter, the two pipeline
// requesters (IF fetch port and MEM load/store port) and the single-port memory.
//
// Modports:
//   slave  : arbiter side (takes requests, drives the memory bus and status)
//   master : environment side (pipeline stages and memory model)
//
// Signal groups:
//   fetch  : if_req, if_addr, if_rdata, if_valid, if_stall, flush
//   data   : d_req, d_we, d_addr, d_wdata, d_rdata, d_valid, d_stall
//   memory : mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ready
//   status : err
// -----------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              flush;

  // Data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  // Memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Status
  logic              err;

  modport slave (
    input  if_req, if_addr, flush,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output if_rdata, if_valid, if_stall,
    output d_rdata, d_valid, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output err
  );

  modport master (
    output if_req, if_addr, flush,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  if_rdata, if_valid, if_stall,
    input  d_rdata, d_valid, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port instruction/data memory between the IF stage (fetch)
// and the MEM stage (LW/SW). One transaction at a time, data has fixed
// priority, each transaction is bounded by a timeout.
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : unified_mem_arbiter_if.slave (fetch, data, memory and err signals)
//
// Parameters:
//   ADDR_W, DATA_W : address / data width
//   TIMEOUT        : cycles to wait for mem_ready before aborting
//   MAX_DATA_WINS  : consecutive data grants tolerated while fetch waits
//                    (only present when STARVE_GUARD_EN is defined)
//
// Build option:
//   STARVE_GUARD_EN : when defined, fetch is forced through after
//                     MAX_DATA_WINS back-to-back data grants; when undefined,
//                     data priority is strict.
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
`ifdef STARVE_GUARD_EN
  , parameter int MAX_DATA_WINS = 4
`endif
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DATA
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_mem_we;
  logic [DATA_W-1:0]  r_if_rdata;
  logic [DATA_W-1:0]  r_d_rdata;
  logic               r_if_valid;
  logic               r_d_valid;
  logic               r_err;
  logic               r_cancel;     // current fetch was flushed; drop its result
  logic [TMO_W-1:0]   r_tmo_cnt;

  logic               w_idle;
  logic               w_active;
  logic               w_force_f;    // starvation guard overrides data priority
  logic               w_grant_d;
  logic               w_grant_f;
  logic               w_timeout;
  logic               w_drop_fetch;

  assign w_idle   = (r_state == S_IDLE);
  assign w_active = !w_idle;

  // ---------------------------------------------------------------------------
  // Optional starvation guard
  // ---------------------------------------------------------------------------
`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_DATA_WINS + 1);

  logic [SW-1:0] r_starve_cnt;

  assign w_force_f = (r_starve_cnt == SW'(MAX_DATA_WINS)) && bus.if_req && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!bus.if_req || w_grant_f) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d && (r_starve_cnt != SW'(MAX_DATA_WINS))) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end
`else
  assign w_force_f = 1'b0;
`endif

  // Arbitration happens only in IDLE; flush blocks a fetch grant that cycle.
  assign w_grant_d = w_idle && bus.d_req && !w_force_f;
  assign w_grant_f = w_idle && bus.if_req && !bus.flush && !w_grant_d;

  // Abort on the cycle the counter would reach TIMEOUT without mem_ready.
  assign w_timeout = w_active && !bus.mem_ready && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

  // A flush arriving together with completion still cancels the fetch.
  assign w_drop_fetch = r_cancel || bus.flush;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt -- no latch.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_d)      w_state_nxt = S_DATA;
        else if (w_grant_f) w_state_nxt = S_FETCH;
      end
      S_FETCH, S_DATA: begin
        if (bus.mem_ready || w_timeout) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_req = w_active;
    bus.mem_we  = (r_state == S_DATA) && r_mem_we;   // never asserted for fetch
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_valid   = r_d_valid;
  assign bus.err       = r_err;
  assign bus.if_stall  = bus.if_req && !r_if_valid;
  assign bus.d_stall   = bus.d_req  && !r_d_valid;

  // ---------------------------------------------------------------------------
  // Datapath: request latch, timeout counter, completion capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_err       <= 1'b0;
      r_cancel    <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      // Completion and error strobes last exactly one cycle.
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_err      <= 1'b0;

      if (w_grant_d) begin
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
        r_mem_we    <= bus.d_we;
        r_tmo_cnt   <= '0;
        r_cancel    <= 1'b0;
      end else if (w_grant_f) begin
        r_mem_addr  <= bus.if_addr;
        r_mem_we    <= 1'b0;
        r_tmo_cnt   <= '0;
        r_cancel    <= 1'b0;
      end

      if ((r_state == S_FETCH) && bus.flush) r_cancel <= 1'b1;

      if (w_active && bus.mem_ready) begin
        if (r_state == S_DATA) begin
          r_d_valid <= 1'b1;
          if (!r_mem_we) r_d_rdata <= bus.mem_rdata;   // stores leave d_rdata alone
        end else if (!w_drop_fetch) begin
          r_if_valid <= 1'b1;
          r_if_rdata <= bus.mem_rdata;
        end
      end else if (w_timeout) begin
        r_err <= 1'b1;
        if (r_state == S_DATA) begin
          r_d_valid <= 1'b1;
          r_d_rdata <= '0;
        end else if (!w_drop_fetch) begin
          r_if_valid <= 1'b1;
          r_if_rdata <= '0;
        end
      end else if (w_active) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Directed bench for unified_mem_arbiter (TIMEOUT overridden to 4).
// Inputs are driven and outputs sampled on the falling clock edge. A requester
// drops its request in the cycle it sees its valid pulse, before the next
// rising edge, so the arbiter's IDLE cycle after a completion sees the
// updated request lines.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic exp_f [6];   // expected grant order for the starvation test, 1 = fetch
  int   n_grants;

  initial begin
`ifdef STARVE_GUARD_EN
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_f = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.flush     = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (3) tick();

    // ---------------- Reset state ----------------
    check("rst_mem_req",  bus.mem_req,  1'b0);
    check("rst_mem_we",   bus.mem_we,   1'b0);
    check("rst_if_valid", bus.if_valid, 1'b0);
    check("rst_d_valid",  bus.d_valid,  1'b0);
    check("rst_err",      bus.err,      1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_d_rdata",  bus.d_rdata,  32'h0);
    rst = 1'b0;
    tick();

    // ---------------- Fetch only ----------------
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    #1;
    check("f_stall_req",   bus.if_stall, 1'b1);
    check("f_memreq_n",    bus.mem_req,  1'b0);
    tick();
    check("f_memreq_n1",   bus.mem_req,  1'b1);
    check("f_mem_addr",    bus.mem_addr, 32'h40);
    check("f_mem_we",      bus.mem_we,   1'b0);
    check("f_valid_early", bus.if_valid, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h8C22_0004;
    tick();
    check("f_valid",       bus.if_valid, 1'b1);
    check("f_rdata",       bus.if_rdata, 32'h8C22_0004);
    check("f_memreq_done", bus.mem_req,  1'b0);
    check("f_stall_done",  bus.if_stall, 1'b0);
    bus.mem_ready = 1'b0;
    bus.if_req    = 1'b0;
    tick();
    check("f_valid_pulse", bus.if_valid, 1'b0);
    check("f_no_regrant",  bus.mem_req,  1'b0);

    // ---------------- Conflict: data wins, then fetch ----------------
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h44;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h100;
    tick();
    check("c_memreq_d",   bus.mem_req,  1'b1);
    check("c_addr_d",     bus.mem_addr, 32'h100);
    check("c_we_d",       bus.mem_we,   1'b0);
    check("c_if_stall1",  bus.if_stall, 1'b1);
    check("c_d_stall1",   bus.d_stall,  1'b1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    tick();
    check("c_d_valid",    bus.d_valid,  1'b1);
    check("c_d_rdata",    bus.d_rdata,  32'h1111_2222);
    check("c_bubble",     bus.mem_req,  1'b0);
    check("c_if_valid_n", bus.if_valid, 1'b0);
    check("c_if_stall2",  bus.if_stall, 1'b1);
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    check("c_memreq_f",   bus.mem_req,  1'b1);
    check("c_addr_f",     bus.mem_addr, 32'h44);
    check("c_if_stall3",  bus.if_stall, 1'b1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h3333_4444;
    tick();
    check("c_if_valid",   bus.if_valid, 1'b1);
    check("c_if_rdata",   bus.if_rdata, 32'h3333_4444);
    check("c_d_rdata_kp", bus.d_rdata,  32'h1111_2222);
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();

    // ---------------- Store with 3-cycle memory latency ----------------
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h8;
    bus.d_wdata = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("s_memreq%0d", i), bus.mem_req,   1'b1);
      check($sformatf("s_we%0d", i),     bus.mem_we,    1'b1);
      check($sformatf("s_addr%0d", i),   bus.mem_addr,  32'h8);
      check($sformatf("s_wdata%0d", i),  bus.mem_wdata, 32'hCAFE_0001);
      check($sformatf("s_valid%0d", i),  bus.d_valid,   1'b0);
      if (i == 2) bus.mem_ready = 1'b1;
    end
    tick();
    check("s_d_valid",    bus.d_valid, 1'b1);
    check("s_we_off",     bus.mem_we,  1'b0);
    check("s_memreq_off", bus.mem_req, 1'b0);
    check("s_d_rdata_kp", bus.d_rdata, 32'h1111_2222);
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    check("s_valid_once", bus.d_valid, 1'b0);

    // ---------------- Flush during a pending fetch ----------------
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    tick();
    check("fl_memreq1", bus.mem_req, 1'b1);
    bus.flush = 1'b1;
    tick();
    check("fl_memreq2", bus.mem_req, 1'b1);
    bus.flush  = 1'b0;
    bus.if_req = 1'b0;
    tick();
    check("fl_memreq3", bus.mem_req, 1'b1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("fl_no_valid", bus.if_valid, 1'b0);
    check("fl_rdata_kp", bus.if_rdata, 32'h3333_4444);
    check("fl_idle",     bus.mem_req,  1'b0);
    bus.mem_ready = 1'b0;
    tick();
    check("fl_no_valid2", bus.if_valid, 1'b0);
    check("fl_idle2",     bus.mem_req,  1'b0);

    // ---------------- Flush in IDLE blocks the grant; flush with ready ----------------
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h90;
    bus.flush   = 1'b1;
    tick();
    check("fi_blocked", bus.mem_req, 1'b0);
    bus.flush = 1'b0;
    tick();
    check("fi_memreq",  bus.mem_req,  1'b1);
    check("fi_addr",    bus.mem_addr, 32'h90);
    bus.flush     = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_0077;
    tick();
    check("fr_no_valid", bus.if_valid, 1'b0);
    check("fr_rdata_kp", bus.if_rdata, 32'h3333_4444);
    check("fr_idle",     bus.mem_req,  1'b0);
    bus.flush     = 1'b0;
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();

    // ---------------- Timeout on a load (TIMEOUT = 4) ----------------
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t_memreq%0d", i), bus.mem_req, 1'b1);
      check($sformatf("t_err%0d", i),    bus.err,     1'b0);
    end
    tick();
    check("t_memreq_off", bus.mem_req, 1'b0);
    check("t_err",        bus.err,     1'b1);
    check("t_d_valid",    bus.d_valid, 1'b1);
    check("t_d_rdata",    bus.d_rdata, 32'h0);
    bus.d_req = 1'b0;
    tick();
    check("t_err_pulse",   bus.err,     1'b0);
    check("t_valid_pulse", bus.d_valid, 1'b0);

    // ---------------- Both requests held: grant order ----------------
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h400;
    n_grants    = 0;
    for (int cyc = 0; cyc < 60 && n_grants < 6; cyc++) begin
      tick();
      if (bus.mem_req) begin
        check($sformatf("sg_grant%0d", n_grants), bus.mem_addr == 32'h300, exp_f[n_grants]);
        n_grants++;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5A5A_0000 + 32'(n_grants);
      end else begin
        bus.mem_ready = 1'b0;
      end
    end
    check("sg_count", n_grants, 6);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    tick();
    bus.mem_ready = 1'b0;
    repeat (2) tick();
    check("sg_d_rdata_set", bus.d_rdata != 32'h0, 1'b1);

    // ---------------- Reset in the middle of a transaction ----------------
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h500;
    tick();
    check("mr_memreq", bus.mem_req, 1'b1);
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_ABCD;
    tick();
    check("mr_memreq_off", bus.mem_req,  1'b0);
    check("mr_no_valid",   bus.d_valid,  1'b0);
    check("mr_no_err",     bus.err,      1'b0);
    check("mr_addr",       bus.mem_addr, 32'h0);
    check("mr_d_rdata",    bus.d_rdata,  32'h0);
    rst           = 1'b0;
    bus.d_req     = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    check("mr_no_valid2", bus.d_valid, 1'b0);
    check("mr_idle",      bus.mem_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
